// File: rtl/silly_pattern_gen.sv
// Multi-channel divided-clock / pulse pattern generator with glitch-safe output enables.
// Optional macro PHASE_SYNC_EN adds sync_in, which re-aligns every channel's counter and phase.
module silly_pattern_gen #(
  parameter int NUM_CH = 8,
  parameter int DIV_W  = 8,
  parameter int CH_W   = 3
) (
  input  logic              clk,
  input  logic              reset,
`ifdef PHASE_SYNC_EN
  input  logic              sync_in,
`endif
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic [1:0]        cfg_mode,
  output logic              cfg_err,
  input  logic [NUM_CH-1:0] en_mask,
  output logic [NUM_CH-1:0] pat_out
);

  typedef enum logic [1:0] {
    MODE_OFF        = 2'b00,
    MODE_SQUARE     = 2'b01,
    MODE_PULSE      = 2'b10,
    MODE_SQUARE_INV = 2'b11
  } mode_t;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_APPLY = 1'b1
  } cfgState_t;

  localparam logic [CH_W:0] NUM_CH_L = (CH_W+1)'(NUM_CH);

  cfgState_t         r_state;
  cfgState_t         w_nextState;
  logic              r_errFlag;
  logic              w_accept;
  logic              w_inRange;
  logic              w_sync;
  logic [NUM_CH-1:0] w_raw;
  logic [NUM_CH-1:0] w_safe;
  logic [NUM_CH-1:0] r_maskQ;
  logic [NUM_CH-1:0] r_enActive;
  logic [NUM_CH-1:0] r_pat;

`ifdef PHASE_SYNC_EN
  assign w_sync = sync_in;
`else
  assign w_sync = 1'b0;
`endif

  assign w_inRange = ({1'b0, cfg_ch} < NUM_CH_L);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_errFlag <= 1'b0;
    end else begin
      r_state <= w_nextState;
      if (w_accept) r_errFlag <= ~w_inRange;
    end
  end

  // Every accepted write is followed by one busy cycle; the error flag is only shown then.
  always_comb begin
    w_nextState = r_state;
    cfg_ready   = 1'b0;
    cfg_err     = 1'b0;
    w_accept    = 1'b0;
    case (r_state)
      S_IDLE: begin
        cfg_ready = 1'b1;
        w_accept  = cfg_valid;
        if (cfg_valid) w_nextState = S_APPLY;
      end
      S_APPLY: begin
        cfg_err     = r_errFlag;
        w_nextState = S_IDLE;
      end
      default: w_nextState = S_IDLE;
    endcase
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : gCh
    logic [DIV_W-1:0] r_div;
    logic [DIV_W-1:0] r_cnt;
    mode_t            r_mode;
    logic             r_phase;
    logic             w_wr;
    logic             w_wrap;

    assign w_wr   = w_accept && w_inRange && (cfg_ch == CH_W'(g));
    assign w_wrap = (r_cnt == r_div);

    assign w_raw[g] = (r_mode == MODE_SQUARE)     ? r_phase  :
                      (r_mode == MODE_PULSE)      ? w_wrap   :
                      (r_mode == MODE_SQUARE_INV) ? ~r_phase : 1'b0;

    // A channel's enable may only move while its output is low, so no high pulse is cut short.
    assign w_safe[g] = ~w_raw[g] | ((r_mode == MODE_PULSE) & ~w_wrap);

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_div   <= '0;
        r_cnt   <= '0;
        r_mode  <= MODE_OFF;
        r_phase <= 1'b0;
      end else if (w_wr) begin
        r_div   <= cfg_div;
        r_mode  <= mode_t'(cfg_mode);
        r_cnt   <= '0;
        r_phase <= 1'b0;
      end else if (w_sync || (r_mode == MODE_OFF)) begin
        r_cnt   <= '0;
        r_phase <= 1'b0;
      end else if (w_wrap) begin
        r_cnt   <= '0;
        r_phase <= ~r_phase;
      end else begin
        r_cnt   <= r_cnt + DIV_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_maskQ    <= '0;
      r_enActive <= '0;
      r_pat      <= '0;
    end else begin
      r_maskQ    <= en_mask;
      r_enActive <= (r_enActive & ~w_safe) | (r_maskQ & w_safe);
      r_pat      <= w_raw & r_enActive;
    end
  end

  assign pat_out = r_pat;

endmodule

// File: tb/tb_silly_pattern_gen.sv
// Self-checking bench for silly_pattern_gen: random config/mask traffic against a time-based model.
// Also exercises the no-runt enable behaviour and an asynchronous reset during a config write.
module tb_silly_pattern_gen;

  localparam int NUM_CH = 8;
  localparam int DIV_W  = 8;
  localparam int CH_W   = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              syncIn;
  logic              cfg_valid;
  logic              cfg_ready;
  logic [CH_W-1:0]   cfg_ch;
  logic [DIV_W-1:0]  cfg_div;
  logic [1:0]        cfg_mode;
  logic              cfg_err;
  logic [NUM_CH-1:0] en_mask;
  logic [NUM_CH-1:0] pat_out;

  int testsRun    = 0;
  int testsFailed = 0;

  // Model: each channel remembers how many cycles have elapsed since its last clear.
  int                mDiv  [NUM_CH];
  int                mMode [NUM_CH];
  int                mT    [NUM_CH];
  logic [NUM_CH-1:0] mMaskQ;
  logic [NUM_CH-1:0] mEnAct;
  logic [NUM_CH-1:0] mPat;
  logic              mReady;
  logic              mErr;

  silly_pattern_gen #(
    .NUM_CH (NUM_CH),
    .DIV_W  (DIV_W),
    .CH_W   (CH_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
`ifdef PHASE_SYNC_EN
    .sync_in   (syncIn),
`endif
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_ch    (cfg_ch),
    .cfg_div   (cfg_div),
    .cfg_mode  (cfg_mode),
    .cfg_err   (cfg_err),
    .en_mask   (en_mask),
    .pat_out   (pat_out)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  function automatic bit modelRaw(input int i);
    int period;
    int pos;
    int half;
    period = mDiv[i] + 1;
    pos    = mT[i] % period;
    half   = (mT[i] / period) % 2;
    case (mMode[i])
      1:       return half == 1;
      2:       return pos == mDiv[i];
      3:       return half == 0;
      default: return 1'b0;
    endcase
  endfunction

  task automatic modelReset();
    for (int i = 0; i < NUM_CH; i++) begin
      mDiv[i]  = 0;
      mMode[i] = 0;
      mT[i]    = 0;
    end
    mMaskQ = '0;
    mEnAct = '0;
    mPat   = '0;
    mReady = 1'b1;
    mErr   = 1'b0;
  endtask

  task automatic modelStep(input logic v, input int ch, input int d, input int m,
                           input logic [NUM_CH-1:0] mask, input logic s);
    logic [NUM_CH-1:0] raw;
    logic [NUM_CH-1:0] safe;
    bit accept;
    bit doSync;
`ifdef PHASE_SYNC_EN
    doSync = s;
`else
    doSync = 1'b0;
`endif
    for (int i = 0; i < NUM_CH; i++) begin
      raw[i]  = modelRaw(i);
      safe[i] = !raw[i] || (mMode[i] == 2 && (mT[i] % (mDiv[i] + 1)) != mDiv[i]);
    end
    mPat = raw & mEnAct;
    for (int i = 0; i < NUM_CH; i++)
      if (safe[i]) mEnAct[i] = mMaskQ[i];
    mMaskQ = mask;
    for (int i = 0; i < NUM_CH; i++) begin
      if (mMode[i] == 0 || doSync) mT[i] = 0;
      else                         mT[i] = (mT[i] + 1) % (2 * (mDiv[i] + 1));
    end
    accept = v && mReady;
    mErr   = accept && (ch >= NUM_CH);
    if (accept && ch < NUM_CH) begin
      mDiv[ch]  = d;
      mMode[ch] = m;
      mT[ch]    = 0;
    end
    mReady = !accept;
  endtask

  task automatic compareState(input string tag);
    checkOutput({tag, ".pat"},   32'(pat_out),   32'(mPat));
    checkOutput({tag, ".ready"}, 32'(cfg_ready), 32'(mReady));
    checkOutput({tag, ".err"},   32'(cfg_err),   32'(mErr));
  endtask

  // Called at a falling edge: check the last rising edge, then drive and predict the next one.
  task automatic applyStimulus(input string tag, input logic v, input logic [CH_W-1:0] ch,
                               input logic [DIV_W-1:0] d, input logic [1:0] m,
                               input logic [NUM_CH-1:0] mask, input logic s);
    compareState(tag);
    cfg_valid = v;
    cfg_ch    = ch;
    cfg_div   = d;
    cfg_mode  = m;
    en_mask   = mask;
    syncIn    = s;
    modelStep(v, int'(ch), int'(d), int'(m), mask, s);
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int highs;
    bit found;
    logic prevPat;
    logic [NUM_CH-1:0] mask;

    reset     = 1'b1;
    syncIn    = 1'b0;
    cfg_valid = 1'b0;
    cfg_ch    = '0;
    cfg_div   = '0;
    cfg_mode  = '0;
    en_mask   = '0;
    modelReset();
    repeat (2) @(negedge clk);
    compareState("reset");
    reset = 1'b0;

    // ch0 divide 3 square; drop its enable on the first high cycle of a pulse.
    applyStimulus("runtCfg", 1'b1, 4'd0, 8'd3, 2'b01, 8'h01, 1'b0);
    for (int i = 0; i < 12; i++) applyStimulus("runtRun", 1'b0, 4'd0, 8'd0, 2'b00, 8'h01, 1'b0);
    found   = 1'b0;
    prevPat = pat_out[0];
    for (int i = 0; i < 20 && !found; i++) begin
      applyStimulus("runtWait", 1'b0, 4'd0, 8'd0, 2'b00, 8'h01, 1'b0);
      if (pat_out[0] && !prevPat) found = 1'b1;
      prevPat = pat_out[0];
    end
    checkOutput("runtRiseSeen", 32'(found), 32'd1);
    highs = 0;
    for (int i = 0; i < 14; i++) begin
      applyStimulus("runtDrop", 1'b0, 4'd0, 8'd0, 2'b00, 8'h00, 1'b0);
      if (pat_out[0]) highs++;
    end
    checkOutput("runtTailHighs", 32'(highs), 32'd3);

    // Out-of-range channel write.
    applyStimulus("errCfg", 1'b1, 4'd9, 8'd5, 2'b10, 8'h00, 1'b0);
    applyStimulus("errApply", 1'b0, 4'd0, 8'd0, 2'b00, 8'h00, 1'b0);

    mask = 8'hff;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      logic              v;
      logic [CH_W-1:0]   ch;
      logic [DIV_W-1:0]  d;
      logic [1:0]        m;
      logic              s;
      v  = ($urandom_range(0, 2) == 0);
      ch = CH_W'($urandom_range(0, 9));
      d  = ($urandom_range(0, 9) == 0) ? DIV_W'($urandom_range(0, 40)) : DIV_W'($urandom_range(0, 5));
      m  = 2'($urandom_range(0, 3));
      s  = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 7) == 0) mask = NUM_CH'($urandom);
      applyStimulus($sformatf("rand%0d", cyc), v, ch, d, m, mask, s);
    end

    // Asynchronous reset while a write is being applied and outputs are toggling.
    applyStimulus("prCfg", 1'b1, 4'd0, 8'd0, 2'b01, 8'hff, 1'b0);
    for (int i = 0; i < 5; i++) applyStimulus("prRun", 1'b0, 4'd0, 8'd0, 2'b00, 8'hff, 1'b0);
    applyStimulus("prWrite", 1'b1, 4'd1, 8'd2, 2'b11, 8'hff, 1'b0);
    compareState("preReset");
    cfg_valid = 1'b0;
    reset     = 1'b1;
    #1;
    checkOutput("asyncPat",   32'(pat_out),   32'd0);
    checkOutput("asyncReady", 32'(cfg_ready), 32'd1);
    checkOutput("asyncErr",   32'(cfg_err),   32'd0);
    modelReset();
    #2;
    reset = 1'b0;
    for (int i = 0; i < 8; i++) applyStimulus("postReset", 1'b0, 4'd0, 8'd0, 2'b00, 8'hff, 1'b0);
    compareState("final");

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
